// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with 3-sample majority vote per bit and a
// first-word-fall-through character FIFO carrying parity/framing/break flags.
module uart_rx_fifo #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        RXD,
  input  logic                        RX_DATA_READ,
  input  logic                        RX_OVERRUN_CLR,
  output logic [DATA_BITS-1:0]        RX_DATA,
  output logic                        RX_PARITY_ERR,
  output logic                        RX_FRAME_ERR,
  output logic                        RX_BREAK,
  output logic                        RX_DATA_VALID,
  output logic                        RX_OVERRUN,
  output logic [$clog2(FIFO_DEPTH):0] RX_FIFO_LEVEL
);

  localparam int unsigned TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW       = $clog2(OVERSAMPLE);
  localparam int unsigned MID      = OVERSAMPLE / 2;
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned LW       = AW + 1;
  localparam int unsigned EW       = DATA_BITS + 3;

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("uart_rx_fifo: CLOCK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end
  if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_oversample
    $error("uart_rx_fifo: OVERSAMPLE must be 8 or 16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_fifo: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  rx_state_e state, state_nx;

  logic                 rxd_meta, rxd_sync, rxd_last;
  logic                 start_edge;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic [SW-1:0]        s_cnt;
  logic                 in_frame, sample_lo, sample_hi, resolve;
  logic [1:0]           samp;
  logic                 maj;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] data_sr;
  logic                 par_bit;
  logic                 fe_acc;
  logic                 clear_cnt;
  logic                 push_req;
  logic                 fe_final, pe_final, brk_final;
  logic [EW-1:0]        push_entry;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_sync <= rxd_meta;
    end
  end

  // rxd_last resets low so a line held low through reset release needs to
  // be seen high once before its falling edge can start a frame.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rxd_last <= 1'b0;
    else          rxd_last <= rxd_sync;
  end

  assign start_edge = rxd_last & ~rxd_sync;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)               tick_cnt <= '0;
    else if (clear_cnt || tick) tick_cnt <= '0;
    else                        tick_cnt <= tick_cnt + 1'b1;
  end

  assign in_frame  = (state != IDLE);
  assign sample_lo = in_frame && tick && (s_cnt == SW'(MID - 1));
  assign sample_hi = in_frame && tick && (s_cnt == SW'(MID));
  assign resolve   = in_frame && tick && (s_cnt == SW'(MID + 1));
  assign maj       = (samp[0] & samp[1]) | (samp[0] & rxd_sync) | (samp[1] & rxd_sync);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_cnt <= '0;
      samp  <= '1;
    end else begin
      if (clear_cnt)
        s_cnt <= '0;
      else if (in_frame && tick)
        s_cnt <= s_cnt + 1'b1;
      if (sample_lo) samp[0] <= rxd_sync;
      if (sample_hi) samp[1] <= rxd_sync;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    clear_cnt = 1'b0;
    push_req  = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nx  = START;
          clear_cnt = 1'b1;
        end
      end
      START: begin
        if (resolve) state_nx = maj ? IDLE : DATA;
      end
      DATA: begin
        if (resolve && bit_idx == 4'(DATA_BITS - 1))
          state_nx = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        if (resolve) state_nx = STOP;
      end
      STOP: begin
        if (resolve && bit_idx == 4'(STOP_BITS - 1)) begin
          state_nx = IDLE;
          push_req = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // bit_idx counts bits within the current field and restarts on every
  // field change, so DATA and STOP share one counter.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bit_idx <= '0;
      data_sr <= '0;
      par_bit <= 1'b0;
      fe_acc  <= 1'b0;
    end else if (clear_cnt) begin
      bit_idx <= '0;
      data_sr <= '0;
      par_bit <= 1'b0;
      fe_acc  <= 1'b0;
    end else if (resolve) begin
      bit_idx <= (state_nx != state) ? 4'd0 : bit_idx + 4'd1;
      case (state)
        DATA: begin
          for (int unsigned i = 0; i < DATA_BITS; i++)
            if (bit_idx == 4'(i)) data_sr[i] <= maj;
        end
        PARITY:  par_bit <= maj;
        STOP:    if (!maj) fe_acc <= 1'b1;
        default: ;
      endcase
    end
  end

  assign fe_final   = fe_acc | ~maj;
  assign pe_final   = (PARITY_EN != 0) && ((^data_sr ^ par_bit) != (PARITY_ODD != 0));
  assign brk_final  = fe_final && (data_sr == '0) && !par_bit;
  assign push_entry = {brk_final, fe_final, pe_final, data_sr};

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, empty, do_push, do_pop;
  logic [EW-1:0] head;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = RX_DATA_READ && !empty;
  assign do_push = push_req && (!full || do_pop);

  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                         RX_OVERRUN <= 1'b0;
    else if (push_req && full && !do_pop) RX_OVERRUN <= 1'b1;
    else if (RX_OVERRUN_CLR)              RX_OVERRUN <= 1'b0;
  end

  // Outputs are gated by occupancy so they read zero whenever the FIFO is
  // empty, including immediately on asynchronous reset.
  assign head          = empty ? '0 : mem[rd_ptr];
  assign RX_DATA       = head[DATA_BITS-1:0];
  assign RX_PARITY_ERR = head[DATA_BITS];
  assign RX_FRAME_ERR  = head[DATA_BITS+1];
  assign RX_BREAK      = head[DATA_BITS+2];
  assign RX_DATA_VALID = !empty;
  assign RX_FIFO_LEVEL = level;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: an 8N1 and an 8E1 instance at 16 clocks
// per bit; expected characters are queued at send time and checked on drain.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rxd0 = 1'b1, rxd1 = 1'b1;
  logic       mon_rd0 = 1'b0, mon_rd1 = 1'b0, stim_rd0 = 1'b0;
  logic       clr0 = 1'b0;
  logic       rd0, rd1;
  logic [7:0] data0, data1;
  logic       pe0, fe0, brk0, valid0, ovr0;
  logic       pe1, fe1, brk1, valid1, ovr1;
  logic [4:0] level0, level1;
  logic       drain0 = 1'b0, drain1 = 1'b0;

  assign rd0 = mon_rd0 | stim_rd0;
  assign rd1 = mon_rd1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] exp0[$];
  logic [10:0] exp1[$];

  uart_rx_fifo #(
    .CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_dut (
    .ACLK(clk), .ARESETN(rst_n), .RXD(rxd0),
    .RX_DATA_READ(rd0), .RX_OVERRUN_CLR(clr0),
    .RX_DATA(data0), .RX_PARITY_ERR(pe0), .RX_FRAME_ERR(fe0), .RX_BREAK(brk0),
    .RX_DATA_VALID(valid0), .RX_OVERRUN(ovr0), .RX_FIFO_LEVEL(level0)
  );

  uart_rx_fifo #(
    .CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_par (
    .ACLK(clk), .ARESETN(rst_n), .RXD(rxd1),
    .RX_DATA_READ(rd1), .RX_OVERRUN_CLR(1'b0),
    .RX_DATA(data1), .RX_PARITY_ERR(pe1), .RX_FRAME_ERR(fe1), .RX_BREAK(brk1),
    .RX_DATA_VALID(valid1), .RX_OVERRUN(ovr1), .RX_FIFO_LEVEL(level1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Entry layout matches the DUT head: {break, frame_err, parity_err, data}.
  always @(negedge clk) begin
    if (drain0 && valid0) begin
      if (exp0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_entry0: got 0x%0h, expected none", {brk0, fe0, pe0, data0});
      end else begin
        chk("entry0", {brk0, fe0, pe0, data0}, exp0.pop_front());
      end
      mon_rd0 = 1'b1;
    end else begin
      mon_rd0 = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (drain1 && valid1) begin
      if (exp1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_entry1: got 0x%0h, expected none", {brk1, fe1, pe1, data1});
      end else begin
        chk("entry1", {brk1, fe1, pe1, data1}, exp1.pop_front());
      end
      mon_rd1 = 1'b1;
    end else begin
      mon_rd1 = 1'b0;
    end
  end

  task automatic set_line(input int sel, input logic b);
    if (sel == 0) rxd0 = b;
    else          rxd1 = b;
  endtask

  task automatic drive(input int sel, input logic b, input int cycles);
    set_line(sel, b);
    repeat (cycles) @(negedge clk);
  endtask

  // mode 1: check push latency around mid-stop; mode 2: pop on the push cycle.
  // Mid-stop push lands on the 157th rising edge after the start bit is driven.
  task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                            input logic pbit, input logic stop, input int mode);
    drive(sel, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(sel, d[i], 16);
    if (has_par) drive(sel, pbit, 16);
    drive(sel, stop, 12);
    if (mode == 1) begin
      chk("level_before_push", level0, 0);
    end else if (mode == 2) begin
      chk("head_at_push_pop", {brk0, fe0, pe0, data0}, exp0.pop_front());
      stim_rd0 = 1'b1;
    end
    @(negedge clk);
    if (mode == 1) begin
      chk("valid_after_push", valid0, 1);
      chk("level_after_push", level0, 1);
    end
    stim_rd0 = 1'b0;
    drive(sel, stop, 3);
    set_line(sel, 1'b1);
  endtask

  task automatic wait_empty0(input string name);
    int n = 0;
    while (level0 != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, level0, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_valid", valid0, 0);
    chk("reset_level", level0, 0);
    chk("reset_data", {brk0, fe0, pe0, data0}, 0);
    chk("reset_overrun", ovr0, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: basic 8N1 frame, latency and pop
    exp0.push_back({3'b000, 8'hA5});
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 1);
    chk("s1_level", level0, 1);
    drain0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("s1_valid_after_read", valid0, 0);
    chk("s1_level_after_read", level0, 0);

    // 2: 4-cycle glitch rejected, then a real frame
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 32);
    chk("s2_glitch_level", level0, 0);
    exp0.push_back({3'b000, 8'h3C});
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1, 0);
    repeat (3) @(negedge clk);
    chk("s2_level", level0, 0);

    // 3: even parity on the parity instance
    drain1 = 1'b1;
    exp1.push_back({3'b000, 8'h3C});
    send_frame(1, 8'h3C, 1, 1'b0, 1'b1, 0);
    exp1.push_back({3'b001, 8'h3C});
    send_frame(1, 8'h3C, 1, 1'b1, 1'b1, 0);
    repeat (3) @(negedge clk);
    chk("s3_level", level1, 0);

    // 4: framing error, break, recovery
    exp0.push_back({3'b010, 8'h55});
    send_frame(0, 8'h55, 0, 1'b0, 1'b0, 0);
    drive(0, 1'b1, 16);
    exp0.push_back({3'b110, 8'h00});
    send_frame(0, 8'h00, 0, 1'b0, 1'b0, 0);
    drive(0, 1'b1, 16);
    exp0.push_back({3'b000, 8'h81});
    send_frame(0, 8'h81, 0, 1'b0, 1'b1, 0);
    repeat (3) @(negedge clk);

    // 5: overrun on 17 back-to-back frames
    drain0 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp0.push_back({3'b000, 8'(i)});
      send_frame(0, 8'(i), 0, 1'b0, 1'b1, 0);
    end
    chk("s5_level_full", level0, 16);
    chk("s5_overrun_set", ovr0, 1);
    drain0 = 1'b1;
    wait_empty0("s5_drain_timeout");
    chk("s5_queue_consumed", exp0.size(), 0);
    chk("s5_overrun_held", ovr0, 1);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    chk("s5_overrun_cleared", ovr0, 0);

    drain0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp0.push_back({3'b000, 8'(8'h20 + i)});
      send_frame(0, 8'(8'h20 + i), 0, 1'b0, 1'b1, 0);
    end
    chk("s5_refill_level", level0, 16);
    exp0.push_back({3'b000, 8'h30});
    send_frame(0, 8'h30, 0, 1'b0, 1'b1, 2);
    chk("s5_pushpop_level", level0, 16);
    chk("s5_pushpop_no_overrun", ovr0, 0);
    drain0 = 1'b1;
    wait_empty0("s5_drain2_timeout");
    chk("s5_queue2_consumed", exp0.size(), 0);

    // 6: async reset during data bit 3 discards everything
    drain0 = 1'b0;
    send_frame(0, 8'h5A, 0, 1'b0, 1'b1, 0);
    chk("s6_pre_valid", valid0, 1);
    drive(0, 1'b0, 16);
    for (int i = 0; i < 3; i++) drive(0, 1'(i < 2), 16);
    drive(0, 1'b0, 8);
    rst_n = 1'b0;
    #1;
    chk("s6_async_valid", valid0, 0);
    chk("s6_async_level", level0, 0);
    chk("s6_async_head", {brk0, fe0, pe0, data0}, 0);
    @(negedge clk);
    drive(0, 1'b1, 4);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    drain0 = 1'b1;
    exp0.push_back({3'b000, 8'hC3});
    send_frame(0, 8'hC3, 0, 1'b0, 1'b1, 0);
    wait_empty0("s6_drain_timeout");

    chk("final_queue0", exp0.size(), 0);
    chk("final_queue1", exp1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
